// File: rtl/priority_decoder.sv
// Index-to-one-hot decoder with a 2-entry valid/ready output buffer,
// a sticky hit mask and a saturating out-of-range error counter.
module priority_decoder #(
  parameter int WIDTH  = 10,
  parameter int CODE_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] din,
  output logic              in_ready,
  output logic [WIDTH-1:0]  dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  mask,
  input  logic              mask_clr,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CODE_W:0] WIDTH_C = (CODE_W + 1)'(WIDTH);

  state_t             state, state_next;
  logic [WIDTH-1:0]   head, head_next;
  logic [WIDTH-1:0]   tail, tail_next;
  logic [WIDTH-1:0]   mask_next;
  logic               err_next;
  logic [ERR_W-1:0]   err_cnt_next;
  logic               legal;
  logic [WIDTH-1:0]   onehot;
  logic               accept;
  logic               push;
  logic               bad;
  logic               pop;

  always_comb begin
    legal  = ({1'b0, din} < WIDTH_C);
    onehot = legal ? (WIDTH'(1) << din) : '0;
    accept = en & in_ready;
    push   = accept & legal;
    bad    = accept & ~legal;
    pop    = out_valid & out_ready;
  end

  // Occupancy FSM: head always drives dout, tail holds the second word.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          head_next  = onehot;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_next = TWO;
          tail_next  = onehot;
        end else if (pop && !push) begin
          state_next = EMPTY;
          head_next  = '0;
        end else if (push && pop) begin
          head_next  = onehot;
        end
      end
      TWO: begin
        if (pop) begin
          state_next = ONE;
          head_next  = tail;
          tail_next  = '0;
        end
      end
      default: begin
        state_next = EMPTY;
        head_next  = '0;
        tail_next  = '0;
      end
    endcase
  end

  // Clear takes effect before the set, so a coincident event survives the clear.
  always_comb begin
    mask_next    = mask_clr ? '0 : mask;
    err_next     = err_clr ? 1'b0 : err;
    err_cnt_next = err_clr ? '0 : err_cnt;
    if (push) begin
      mask_next = mask_next | onehot;
    end
    if (bad) begin
      err_next = 1'b1;
      if (err_cnt_next != '1) begin
        err_cnt_next = err_cnt_next + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mask      <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_next;
      head      <= head_next;
      tail      <= tail_next;
      in_ready  <= (state_next != TWO);
      out_valid <= (state_next != EMPTY);
      mask      <= mask_next;
      err       <= err_next;
      err_cnt   <= err_cnt_next;
    end
  end

  assign dout = head;

endmodule

// File: doc/priority_decoder.md
Name: priority_decoder

Overview:
- Inverse of the team's 10-input priority encoder: accepts a stream of encoded indices ({en, code}) and regenerates one-hot 10-bit vectors.
- Input side is a 2-entry buffered stage with valid/ready backpressure. Output side presents decoded one-hot words.
- Keeps a sticky accumulated hit mask and an out-of-range error counter for status/debug.
- Sits downstream of the encoder, or at the far end of any link carrying its {en, dout} pair.

Parameters:
- WIDTH, 10, number of one-hot output lines; legal codes are 0..WIDTH-1.
- CODE_W, 4, width of the encoded index input; must satisfy 2**CODE_W >= WIDTH.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  input valid; same meaning as the encoder's en output.
- din  input  CODE_W  encoded index; ignored when en=0.
- in_ready  output  1  buffer can accept a word this cycle.
- dout  output  WIDTH  one-hot decoded word at the buffer head.
- out_valid  output  1  dout holds a valid word.
- out_ready  input  1  consumer accepts dout this cycle.
- mask  output  WIDTH  sticky OR of every accepted one-hot word.
- mask_clr  input  1  synchronous clear of mask.
- err  output  1  sticky flag: an out-of-range code was received.
- err_cnt  output  ERR_W  saturating count of out-of-range codes.
- err_clr  input  1  synchronous clear of err and err_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY; in_ready=1; out_valid=0; dout=0.
  - mask=0; err=0; err_cnt=0.
  - Both buffer entries are zeroed.
  - Reset asserted mid-transfer drops all buffered words; no partial beat is emitted.
- Handshakes:
  - Input accept = en & in_ready.
  - Output pop = out_valid & out_ready.
  - All outputs are registered.
- Latency: a word accepted at edge N appears on dout with out_valid=1 after edge N (1-cycle latency when the buffer is empty).
- Decode:
  - A legal code c (c < WIDTH) is stored as the one-hot value 1<<c.
  - An illegal code (c >= WIDTH, e.g. 10..15) is consumed (in_ready is honoured) but is not stored.
  - An illegal code sets err=1 and increments err_cnt, saturating at 2**ERR_W-1.
- State machine: EMPTY, ONE, TWO (occupancy of the 2-entry FIFO, head entry drives dout).
  - EMPTY: legal accept -> ONE.
  - ONE:
    - legal accept without pop -> TWO;
    - pop without legal accept -> EMPTY;
    - legal accept with pop -> ONE, new word becomes head.
  - TWO:
    - pop -> ONE, second entry moves to head;
    - no accept is possible because in_ready=0.
  - in_ready = (state != TWO). It is a registered function of state, so there is no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- mask:
  - mask |= onehot on every legal accept.
  - mask_clr alone forces mask to 0.
  - mask_clr coincident with a legal accept gives mask = that word's onehot only (clear first, then set).
- err:
  - err_clr coincident with an illegal code gives err=1 and err_cnt=1.
  - At saturation, err_cnt holds its value.
- Ordering: words leave in acceptance order. Illegal codes never occupy a slot and never reorder legal words.
- en=0: din is ignored; no state change.

Test Plan:
- Reset, then en=1, din=0 for one cycle, out_ready=1 -> next cycle dout=10'b0000000001, out_valid=1, mask=0x001; after the pop, out_valid=0.
- Codes 9, 3, 5 streamed back-to-back with out_ready=0 -> 9 and 3 are accepted, in_ready=0 during the third cycle so 5 is held by the source, state=TWO, dout=0x200. Then out_ready=1 -> dout=0x200, then 0x008, then 0x020; mask=0x228.
- din=12 with en=1 -> no out_valid; err=1, err_cnt=1, mask unchanged. Then 300 illegal codes -> err_cnt=255 (saturated).
- mask_clr asserted in the same cycle as an accept of code 4 -> mask=0x010. err_clr in the same cycle as din=15 -> err=1, err_cnt=1.
- Continuous en=1 with out_ready=1 while cycling codes 0..9 -> one word per cycle, state stays ONE, each dout is the correct one-hot, mask=0x3FF.
- rst_n pulsed low asynchronously while state=TWO -> out_valid, dout, mask and err_cnt go to 0 immediately; in_ready=1 after release.
